layer_sequencer: RTL and testbench

Controller and collector for one fully-connected layer. It issues `neuron_go` to a shared neuron datapath once per output neuron and captures each signed accumulator result on `neuron_done`. Each result is passed through ReLU, shift-right requantization and saturation, then stored in a flattened 8-bit output vector that feeds the next layer's `in_data`. On the final layer it also tracks the argmax of the raw results, which gives the recognized digit.

---
 rtl/layer_sequencer.sv | 121 ++++++++++++
 tb/tb_layer_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// Sequencer/collector for one fully-connected layer: drives the shared neuron datapath,
// requantizes each result (ReLU, shift, saturate) and, with LAYER_ARGMAX_EN, tracks argmax.
module layer_sequencer #(
  parameter int OUT_SIZE  = 10,
  parameter int WIDTH_ACC = 32,
  parameter int WIDTH_Q   = 8,
  parameter int SHIFT     = 7,
  localparam int IDX_W    = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        layer_go,
  output logic                        neuron_go,
  output logic [IDX_W-1:0]            neuron_index,
  input  logic                        neuron_done,
  input  logic [WIDTH_ACC-1:0]        neuron_result,
  output logic [WIDTH_Q*OUT_SIZE-1:0] out_data,
  output logic                        layer_busy,
  output logic                        layer_done,
  output logic [IDX_W-1:0]            max_index,
  output logic [WIDTH_ACC-1:0]        max_value
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [WIDTH_Q-1:0]   Q_MAX     = {1'b0, {(WIDTH_Q-1){1'b1}}};
  localparam logic [WIDTH_ACC-1:0] Q_MAX_EXT = WIDTH_ACC'(Q_MAX);
  localparam logic [IDX_W-1:0]     K_LAST    = IDX_W'(OUT_SIZE - 1);

  state_t                 state, state_next;
  logic [IDX_W-1:0]       k;
  logic                   start_layer;
  logic                   capture;
  logic                   last;
  logic [WIDTH_ACC-1:0]   relu;
  logic [WIDTH_ACC-1:0]   shifted;
  logic [WIDTH_Q-1:0]     q;

  assign start_layer = (state == S_IDLE) && layer_go;
  assign capture     = (state == S_WAIT) && neuron_done;
  assign last        = (k == K_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (layer_go) state_next = S_START;
      S_START: state_next = S_WAIT;
      S_WAIT:  if (neuron_done) state_next = last ? S_DONE : S_START;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign neuron_go    = (state == S_START);
  assign layer_busy   = (state == S_START) || (state == S_WAIT);
  assign layer_done   = (state == S_DONE);
  assign neuron_index = k;

  // Negative results clamp to zero first, so the shift below never sees a sign bit.
  always_comb begin
    relu    = neuron_result[WIDTH_ACC-1] ? '0 : neuron_result;
    shifted = relu >> SHIFT;
    q       = (shifted > Q_MAX_EXT) ? Q_MAX : shifted[WIDTH_Q-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k <= '0;
    end else if (start_layer) begin
      k <= '0;
    end else if (capture && !last) begin
      k <= k + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data <= '0;
    end else if (start_layer) begin
      out_data <= '0;
    end else if (capture) begin
      out_data[int'(k)*WIDTH_Q +: WIDTH_Q] <= q;
    end
  end

`ifdef LAYER_ARGMAX_EN
  logic signed [WIDTH_ACC-1:0] max_value_r;
  logic        [IDX_W-1:0]     max_index_r;

  // First capture loads unconditionally; strict compare keeps the lowest index on ties.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max_value_r <= '0;
      max_index_r <= '0;
    end else if (start_layer) begin
      max_value_r <= '0;
      max_index_r <= '0;
    end else if (capture && ((k == '0) || ($signed(neuron_result) > max_value_r))) begin
      max_value_r <= $signed(neuron_result);
      max_index_r <= k;
    end
  end

  assign max_index = max_index_r;
  assign max_value = max_value_r;
`else
  assign max_index = '0;
  assign max_value = '0;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboarded bench for layer_sequencer: three instances (OUT_SIZE 4, 10, 1) driven in turn;
// expected layer results are queued at issue and checked by a monitor on layer_done.
module tb_layer_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        go_v = 1'b0;
  logic        done_v = 1'b0;
  logic [31:0] res_v = '0;
  int          sel = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  logic lg0, lg1, lg2, nd0, nd1, nd2;
  assign lg0 = go_v && (sel == 0);
  assign lg1 = go_v && (sel == 1);
  assign lg2 = go_v && (sel == 2);
  assign nd0 = done_v && (sel == 0);
  assign nd1 = done_v && (sel == 1);
  assign nd2 = done_v && (sel == 2);

  logic        ngo0, busy0, ld0;
  logic [1:0]  idx0, mi0;
  logic [31:0] out0, mv0;
  logic        ngo1, busy1, ld1;
  logic [3:0]  idx1, mi1;
  logic [79:0] out1;
  logic [31:0] mv1;
  logic        ngo2, busy2, ld2;
  logic [0:0]  idx2, mi2;
  logic [7:0]  out2;
  logic [31:0] mv2;

  layer_sequencer #(.OUT_SIZE(4), .WIDTH_ACC(32), .WIDTH_Q(8), .SHIFT(7)) dut4 (
    .clk(clk), .reset(reset), .layer_go(lg0), .neuron_go(ngo0), .neuron_index(idx0),
    .neuron_done(nd0), .neuron_result(res_v), .out_data(out0), .layer_busy(busy0),
    .layer_done(ld0), .max_index(mi0), .max_value(mv0));

  layer_sequencer #(.OUT_SIZE(10), .WIDTH_ACC(32), .WIDTH_Q(8), .SHIFT(7)) dut10 (
    .clk(clk), .reset(reset), .layer_go(lg1), .neuron_go(ngo1), .neuron_index(idx1),
    .neuron_done(nd1), .neuron_result(res_v), .out_data(out1), .layer_busy(busy1),
    .layer_done(ld1), .max_index(mi1), .max_value(mv1));

  layer_sequencer #(.OUT_SIZE(1), .WIDTH_ACC(32), .WIDTH_Q(8), .SHIFT(7)) dut1 (
    .clk(clk), .reset(reset), .layer_go(lg2), .neuron_go(ngo2), .neuron_index(idx2),
    .neuron_done(nd2), .neuron_result(res_v), .out_data(out2), .layer_busy(busy2),
    .layer_done(ld2), .max_index(mi2), .max_value(mv2));

  logic        m_ngo, m_busy, m_ld;
  int          m_idx, m_mi;
  logic [79:0] m_out;
  logic [31:0] m_mv;

  always_comb begin
    m_ngo = ngo0; m_busy = busy0; m_ld = ld0; m_idx = int'(idx0); m_mi = int'(mi0);
    m_out = {48'b0, out0}; m_mv = mv0;
    if (sel == 1) begin
      m_ngo = ngo1; m_busy = busy1; m_ld = ld1; m_idx = int'(idx1); m_mi = int'(mi1);
      m_out = out1; m_mv = mv1;
    end else if (sel == 2) begin
      m_ngo = ngo2; m_busy = busy2; m_ld = ld2; m_idx = int'(idx2); m_mi = int'(mi2);
      m_out = {72'b0, out2}; m_mv = mv2;
    end
  end

  typedef struct {
    int          s;
    logic [79:0] od;
    int          mi;
    logic [31:0] mv;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (dut sel %0d) at %0t: got 0x%0h, required 0x%0h", name, sel, $time, act, exp);
    end
  endtask

  // Scoreboard monitor: every layer_done pops one expected layer result.
  always @(negedge clk) begin
    if (m_ld) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_layer_done (dut sel %0d) at %0t: got 1, required 0", sel, $time);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_dut_select", 80'(sel), 80'(e.s));
        chk("sb_out_data", m_out, e.od);
        chk("sb_max_index", 80'(m_mi), 80'(e.mi));
        chk("sb_max_value", {48'b0, m_mv}, {48'b0, e.mv});
      end
    end
  end

  task automatic run_layer(input int s, input int n, input int r[10], input int q[10],
                           input int emi, input int emv, input bit stray, input int abort_at);
    exp_t e;
    int   waited;
    logic [31:0] qv;
    sel = s;
    if (abort_at >= n) begin
      e.s  = s;
      e.od = '0;
      for (int j = 0; j < n; j++) begin
        qv = q[j];
        e.od[j*8 +: 8] = qv[7:0];
      end
`ifdef LAYER_ARGMAX_EN
      e.mi = emi;
      e.mv = emv;
`else
      e.mi = 0;
      e.mv = '0;
`endif
      sbq.push_back(e);
    end
    if (stray) begin
      done_v = 1'b1; res_v = 32'h7fff_ffff;
      @(negedge clk);
      done_v = 1'b0;
    end
    go_v = 1'b1;
    @(negedge clk);
    go_v = 1'b0;
    for (int i = 0; i < n; i++) begin
      waited = 0;
      while (!m_ngo && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      if (!m_ngo) begin
        n_cmp++; n_bad++;
        $display("FAIL neuron_go_timeout (dut sel %0d): got no pulse, required pulse for neuron %0d", s, i);
        return;
      end
      chk("neuron_go_latency", 80'(waited), 80'(0));
      chk("neuron_index", 80'(m_idx), 80'(i));
      if (stray) begin
        done_v = 1'b1; res_v = 32'h7fff_ffff;
      end
      @(negedge clk);
      done_v = 1'b0;
      chk("neuron_go_one_cycle", 80'(m_ngo), 80'(0));
      if (stray && i == 1) go_v = 1'b1;
      @(negedge clk);
      go_v = 1'b0;
      if (i == abort_at) begin
        #2 reset = 1'b0;
        #1;
        chk("rst_out_data", {out1, out0, out2}, '0);
        chk("rst_ctrl", 80'({ngo0, ngo1, ngo2, busy0, busy1, busy2, ld0, ld1, ld2}), '0);
        chk("rst_index", 80'({idx0, idx1, idx2, mi0, mi1, mi2}), '0);
        chk("rst_max_value", 80'({mv0, mv1, mv2}), '0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        return;
      end
      done_v = 1'b1; res_v = r[i];
      @(negedge clk);
      done_v = 1'b0;
      if (i == n - 1) chk("layer_done_latency", 80'(m_ld), 80'(1));
      else            chk("layer_busy", 80'(m_busy), 80'(1));
    end
    @(negedge clk);
    chk("layer_done_single_pulse", 80'(m_ld), 80'(0));
  endtask

  initial begin
    logic [79:0] idle_acc;
    logic        go_seen;
    #10000000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [79:0] idle_acc;
    logic        go_seen;
    idle_acc = '0;
    go_seen  = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      idle_acc = idle_acc | out1 | {48'b0, out0} | {72'b0, out2}
               | 80'({idx0, idx1, idx2, mi0, mi1, mi2, busy0, busy1, busy2, ld0, ld1, ld2})
               | 80'({mv0 | mv1 | mv2});
      go_seen = go_seen | ngo0 | ngo1 | ngo2;
    end
    chk("idle_outputs_zero", idle_acc, '0);
    chk("idle_no_neuron_go", 80'(go_seen), 80'(0));

    run_layer(0, 4, '{1000, 20000, -5, 127, 0, 0, 0, 0, 0, 0},
              '{7, 127, 0, 0, 0, 0, 0, 0, 0, 0}, 1, 20000, 1'b0, 99);
    run_layer(1, 10, '{-3, 50, 900, 900, -1000, 0, 12, 899, 1, 2},
              '{0, 0, 7, 7, 0, 0, 0, 7, 0, 0}, 2, 900, 1'b0, 99);
    run_layer(1, 10, '{-7, -7, -7, -7, -7, -7, -7, -7, -7, -7},
              '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 0, -7, 1'b0, 99);
    run_layer(0, 4, '{128, 16383, 256, 16384, 0, 0, 0, 0, 0, 0},
              '{1, 127, 2, 127, 0, 0, 0, 0, 0, 0}, 3, 16384, 1'b1, 99);
    run_layer(2, 1, '{640, 0, 0, 0, 0, 0, 0, 0, 0, 0},
              '{5, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 0, 640, 1'b0, 99);
    run_layer(2, 1, '{-1, 0, 0, 0, 0, 0, 0, 0, 0, 0},
              '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 0, -1, 1'b0, 99);
    run_layer(1, 10, '{-3, 50, 900, 900, -1000, 0, 12, 899, 1, 2},
              '{0, 0, 7, 7, 0, 0, 0, 7, 0, 0}, 2, 900, 1'b0, 3);
    run_layer(1, 10, '{0, 128, 256, 384, 512, 640, 768, 896, 1024, 1152},
              '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9}, 9, 1152, 1'b0, 99);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 80'(sbq.size()), 80'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
